// File: rtl/alu_pipe_pkg.sv
// Opcode constants shared by the ALU pipeline, its controller and the bench.
package alu_pipe_pkg;

  localparam int OP_CODE_SIZE = 3;

  localparam logic [OP_CODE_SIZE-1:0] OP_OR  = 3'b000;
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR = 3'b001;
  localparam logic [OP_CODE_SIZE-1:0] OP_AND = 3'b010;
  localparam logic [OP_CODE_SIZE-1:0] OP_NOT = 3'b011;
  localparam logic [OP_CODE_SIZE-1:0] OP_ADD = 3'b100;
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB = 3'b101;
  localparam logic [OP_CODE_SIZE-1:0] OP_SHL = 3'b110;
  localparam logic [OP_CODE_SIZE-1:0] OP_SHR = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic, add/sub and single-bit shifts with carry, zero
// and signed-overflow flags.
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int data_size = 8
) (
  input  logic [data_size-1:0]    a,
  input  logic [data_size-1:0]    b,
  input  logic [OP_CODE_SIZE-1:0] op,
  output logic [data_size-1:0]    result,
  output logic                    carry,
  output logic                    zero,
  output logic                    overflow
);

  localparam int MSB = data_size - 1;

  logic [data_size:0] w_sum;
  logic [data_size:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so the top bit reads as "no borrow".
  assign w_diff = {1'b0, a} + {1'b0, ~b} + {{data_size{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_AND: result = a & b;
      OP_NOT: result = ~a;
      OP_ADD: begin
        result   = w_sum[MSB:0];
        carry    = w_sum[data_size];
        overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result   = w_diff[MSB:0];
        carry    = w_diff[data_size];
        overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        carry  = a[MSB];
      end
      OP_SHR: begin
        result = {1'b0, a[MSB:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides; stage 1 holds
// operands, stage 2 holds the computed result and flags.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int data_size    = 8,
  parameter int op_code_size = OP_CODE_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [data_size-1:0]    a_in,
  input  logic [data_size-1:0]    b_in,
  input  logic [op_code_size-1:0] op_code,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_size-1:0]    result_out,
  output logic                    carry_out,
  output logic                    zero_out,
  output logic                    overflow_out
);

  logic                    r_s1_valid;
  logic [data_size-1:0]    r_s1_a;
  logic [data_size-1:0]    r_s1_b;
  logic [op_code_size-1:0] r_s1_op;
  logic                    r_out_valid;
  logic [data_size-1:0]    r_result;
  logic                    r_carry;
  logic                    r_zero;
  logic                    r_overflow;

  logic                    w_s1_load;
  logic                    w_s2_load;
  logic [data_size-1:0]    w_core_result;
  logic                    w_core_carry;
  logic                    w_core_zero;
  logic                    w_core_overflow;

  // Ready ripples back combinationally so a full pipe drains and refills in one edge.
  assign w_s2_load = ~r_out_valid | out_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign in_ready  = w_s1_load;

  alu_core #(
    .data_size(data_size)
  ) u_core (
    .a       (r_s1_a),
    .b       (r_s1_b),
    .op      (r_s1_op),
    .result  (w_core_result),
    .carry   (w_core_carry),
    .zero    (w_core_zero),
    .overflow(w_core_overflow)
  );

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a  <= a_in;
          r_s1_b  <= b_in;
          r_s1_op <= op_code;
        end
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result   <= w_core_result;
          r_carry    <= w_core_carry;
          r_zero     <= w_core_zero;
          r_overflow <= w_core_overflow;
        end
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign result_out   = r_result;
  assign carry_out    = r_carry;
  assign zero_out     = r_zero;
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed scenarios on an 8-bit instance, randomized
// handshake traffic on a 16-bit instance against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, r8;
  logic [2:0] op8 = '0;
  logic       c8, z8, v8;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic [2:0]  op16 = '0;
  logic        c16, z16, v16;

  int n_checks = 0;
  int n_fail = 0;

  alu_pipe #(.data_size(8)) dut8 (
    .clk(clk), .reset_in(reset_in), .in_valid(iv8), .in_ready(ir8),
    .a_in(a8), .b_in(b8), .op_code(op8), .out_valid(ov8), .out_ready(or8),
    .result_out(r8), .carry_out(c8), .zero_out(z8), .overflow_out(v8));

  alu_pipe #(.data_size(16)) dut16 (
    .clk(clk), .reset_in(reset_in), .in_valid(iv16), .in_ready(ir16),
    .a_in(a16), .b_in(b16), .op_code(op16), .out_valid(ov16), .out_ready(or16),
    .result_out(r16), .carry_out(c16), .zero_out(z16), .overflow_out(v16));

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  // Reference: plain integer arithmetic modulo 2^w, signed range test for overflow.
  function automatic exp_t ref_op(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint full = longint'(1) << w;
    longint half = full / 2;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint r = 0;
    longint s;
    exp_t e = '0;
    case (op)
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_AND: r = ua & ub;
      OP_NOT: r = (full - 1) - ua;
      OP_ADD: begin
        r = ua + ub;
        e.c = (r >= full);
        s = sa + sb;
        e.v = (s >= half) || (s < -half);
      end
      OP_SUB: begin
        r = ua - ub;
        e.c = (ua >= ub);
        s = sa - sb;
        e.v = (s >= half) || (s < -half);
      end
      OP_SHL: begin
        r = ua * 2;
        e.c = (ua >= half);
      end
      default: begin
        r = ua / 2;
        e.c = ((ua % 2) == 1);
      end
    endcase
    r = ((r % full) + full) % full;
    e.res = 32'(r);
    e.z = (r == 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_in = 1'b1;
    #1;
    n_checks++;
    if ({ov8, r8, c8, z8, v8} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs8: got %h want 000", {ov8, r8, c8, z8, v8});
    end
    n_checks++;
    if ({ov16, r16, c16, z16, v16} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs16: got %h want 00000", {ov16, r16, c16, z16, v16});
    end
    @(posedge clk);
    tick();
    reset_in = 1'b0;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", ir8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[3] = '{OP_ADD, OP_SUB, OP_SHL};
    logic [7:0] as[3] = '{8'h7F, 8'h00, 8'h80};
    logic [7:0] bs[3] = '{8'h01, 8'h01, 8'h00};
    logic [7:0] er[3] = '{8'h80, 8'hFF, 8'h00};
    logic [2:0] eczv[3] = '{3'b001, 3'b000, 3'b110};
    int k = 0;
    or8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iv8 = (i < 3);
      if (i < 3) begin
        op8 = ops[i]; a8 = as[i]; b8 = bs[i];
      end
      #1;
      n_checks++;
      if (ov8 !== (i >= 2 && i <= 4)) begin
        n_fail++;
        $display("FAIL b2b_out_valid cycle %0d: got %b want %b", i, ov8, (i >= 2 && i <= 4));
      end
      if (i < 3) begin
        n_checks++;
        if (ir8 !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_in_ready cycle %0d: got %b want 1", i, ir8);
        end
      end
      if (ov8 === 1'b1 && k < 3) begin
        n_checks++;
        if (r8 !== er[k]) begin
          n_fail++;
          $display("FAIL b2b_result %0d: got %h want %h", k, r8, er[k]);
        end
        n_checks++;
        if ({c8, z8, v8} !== eczv[k]) begin
          n_fail++;
          $display("FAIL b2b_flags %0d: got czv=%b want %b", k, {c8, z8, v8}, eczv[k]);
        end
        k++;
      end
      tick();
    end
  endtask

  task automatic test_logic_ops();
    logic [2:0] ops[4] = '{OP_OR, OP_XOR, OP_AND, OP_NOT};
    logic [7:0] er[4] = '{8'hFC, 8'hCC, 8'h30, 8'h0F};
    int k = 0;
    or8 = 1'b1;
    a8 = 8'hF0;
    b8 = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      iv8 = (i < 4);
      if (i < 4) op8 = ops[i];
      #1;
      if (ov8 === 1'b1 && k < 4) begin
        n_checks++;
        if (r8 !== er[k]) begin
          n_fail++;
          $display("FAIL logic_result %0d: got %h want %h", k, r8, er[k]);
        end
        n_checks++;
        if ({c8, z8, v8} !== 3'b000) begin
          n_fail++;
          $display("FAIL logic_flags %0d: got czv=%b want 000", k, {c8, z8, v8});
        end
        k++;
      end
      tick();
    end
    n_checks++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL logic_count: got %0d want 4", k);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] pop[4];
    logic [7:0] pa[4], pb[4];
    exp_t q[$];
    exp_t e;
    logic [10:0] frozen = '0;
    bit have = 0;
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      pop[i] = 3'($urandom_range(7));
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    or8 = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      iv8 = (idx < 4);
      if (idx < 4) begin
        op8 = pop[idx]; a8 = pa[idx]; b8 = pb[idx];
      end
      #1;
      if (ov8 === 1'b1) begin
        if (have) begin
          n_checks++;
          if ({r8, c8, z8, v8} !== frozen) begin
            n_fail++;
            $display("FAIL bp_frozen cycle %0d: got %h want %h", cyc, {r8, c8, z8, v8}, frozen);
          end
        end
        frozen = {r8, c8, z8, v8};
        have = 1;
      end
      if (iv8 && ir8) begin
        q.push_back(ref_op(8, op8, 32'(a8), 32'(b8)));
        idx++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (idx != 2) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d want 2", idx);
    end
    n_checks++;
    if (ir8 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_in_ready_stall: got %b want 0", ir8);
    end
    or8 = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      iv8 = (idx < 4);
      if (idx < 4) begin
        op8 = pop[idx]; a8 = pa[idx]; b8 = pb[idx];
      end
      #1;
      if (ov8 === 1'b1) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_result: got %h want none", r8);
        end else begin
          e = q.pop_front();
          if ({r8, c8, z8, v8} !== {e.res[7:0], e.c, e.z, e.v}) begin
            n_fail++;
            $display("FAIL bp_result %0d: got %h want %h", got, {r8, c8, z8, v8},
                     {e.res[7:0], e.c, e.z, e.v});
          end
        end
        got++;
      end
      if (iv8 && ir8) begin
        q.push_back(ref_op(8, op8, 32'(a8), 32'(b8)));
        idx++;
      end
      tick();
    end
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_result_count: got %0d want 4", got);
    end
    iv8 = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      n_checks++;
      if (ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_duplicate cycle %0d: got out_valid %b want 0", cyc, ov8);
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    or8 = 1'b0;
    iv8 = 1'b1;
    op8 = OP_ADD;
    a8 = 8'h11;
    b8 = 8'h22;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (ov8 === 1'b1 && ir8 === 1'b0) break;
      tick();
    end
    n_checks++;
    if ({ov8, ir8} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_fill: got valid/ready %b want 10", {ov8, ir8});
    end
    reset_in = 1'b1;
    #1;
    n_checks++;
    if ({ov8, r8, c8, z8, v8} !== 12'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h want 000", {ov8, r8, c8, z8, v8});
    end
    tick();
    reset_in = 1'b0;
    iv8 = 1'b0;
    or8 = 1'b1;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_ready: got %b want 1", ir8);
    end
    tick();
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      n_checks++;
      if (ov8 !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale cycle %0d: got out_valid %b result %h want 0", cyc, ov8, r8);
      end
      tick();
    end
  endtask

  task automatic test_random_traffic();
    exp_t q[$];
    exp_t e;
    int accepted = 0;
    int cycles = 0;
    while ((accepted < 10000 || q.size() > 0) && cycles < 60000) begin
      iv16 = (accepted < 10000) && ($urandom_range(3) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      op16 = 3'($urandom_range(7));
      or16 = ($urandom_range(3) != 0);
      #1;
      if (ov16 && or16) begin
        n_checks++;
        if (z16 !== (r16 == 16'h0)) begin
          n_fail++;
          $display("FAIL rnd_zero_consistency: got z=%b result %h", z16, r16);
        end
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra_result: got %h want none", r16);
        end else begin
          e = q.pop_front();
          if ({r16, c16, z16, v16} !== {e.res[15:0], e.c, e.z, e.v}) begin
            n_fail++;
            $display("FAIL rnd_result: got %h czv=%b want %h czv=%b", r16, {c16, z16, v16},
                     e.res[15:0], {e.c, e.z, e.v});
          end
        end
      end
      if (iv16 && ir16) begin
        q.push_back(ref_op(16, op16, 32'(a16), 32'(b16)));
        accepted++;
      end
      tick();
      cycles++;
    end
    iv16 = 1'b0;
    n_checks++;
    if (cycles >= 60000) begin
      n_fail++;
      $display("FAIL rnd_timeout: got %0d accepted %0d pending want drained", accepted, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_logic_ops();
    test_backpressure();
    test_reset_midstream();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
